// File: rtl/mem_stage_if.sv
// mem_stage_if
// Groups the EX/MEM inputs, the MEM/WB outputs and the debug read port of
// the memory-access stage into one bundle.
//   master : upstream/driver side (drives i_*, observes o_*)
//   slave  : mem_stage side (observes i_*, drives o_*)
// Signals:
//   i_aluresult  32  byte address / pass-through value
//   i_regB       32  store data
//   i_rd_rt       5  destination register
//   i_mem         3  [0] mem_read, [1] mem_write, [2] branch (unused)
//   i_wb          2  [0] reg_write, [1] mem_to_reg
//   i_sizemem     2  00 byte, 01 half, 1x word
//   i_signedmem   1  sign-extend loads when 1
//   i_debug_addr  ADDR_WIDTH  debug word index
//   o_readdata, o_aluresult, o_rd_rt, o_wb, o_misaligned : MEM/WB register
//   o_debug_data 32  memory word at i_debug_addr (combinational)
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [31:0]           i_aluresult;
    logic [31:0]           i_regB;
    logic [4:0]            i_rd_rt;
    logic [2:0]            i_mem;
    logic [1:0]            i_wb;
    logic [1:0]            i_sizemem;
    logic                  i_signedmem;
    logic [ADDR_WIDTH-1:0] i_debug_addr;
    logic [31:0]           o_readdata;
    logic [31:0]           o_aluresult;
    logic [4:0]            o_rd_rt;
    logic [1:0]            o_wb;
    logic                  o_misaligned;
    logic [31:0]           o_debug_data;

    modport master (
        output i_aluresult, i_regB, i_rd_rt, i_mem, i_wb, i_sizemem,
               i_signedmem, i_debug_addr,
        input  o_readdata, o_aluresult, o_rd_rt, o_wb, o_misaligned,
               o_debug_data
    );

    modport slave (
        input  i_aluresult, i_regB, i_rd_rt, i_mem, i_wb, i_sizemem,
               i_signedmem, i_debug_addr,
        output o_readdata, o_aluresult, o_rd_rt, o_wb, o_misaligned,
               o_debug_data
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of a 5-stage MIPS pipeline: byte/halfword/word loads
// and stores against an internal little-endian data memory, registered as
// the MEM/WB pipeline register, plus a combinational debug word read.
// Ports:
//   i_clock  1  rising-edge clock
//   i_reset  1  synchronous active-high reset (memory contents kept)
//   bus         mem_stage_if.slave (EX/MEM inputs, MEM/WB outputs, debug)
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    mem_stage_if.slave  bus
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [31:0]           r_readdata;
    logic [31:0]           r_aluresult;
    logic [4:0]            r_rd_rt;
    logic [1:0]            r_wb;
    logic                  r_misaligned;

    logic                  w_mem_read;
    logic                  w_mem_write;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_align_err;
    logic                  w_misaligned;
    logic                  w_do_store;
    logic                  w_do_load;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_loadval;
    logic [31:0]           w_readdata;
    logic                  w_unused;

    assign w_mem_read  = bus.i_mem[0];
    assign w_mem_write = bus.i_mem[1];
    // Upper address bits wrap; branch flag belongs to another stage.
    assign w_unused    = ^{bus.i_mem[2], bus.i_aluresult[31:ADDR_WIDTH+2]};

    assign w_idx     = bus.i_aluresult[ADDR_WIDTH+1:2];
    assign w_off     = bus.i_aluresult[1:0];
    assign w_is_byte = (bus.i_sizemem == 2'b00);
    assign w_is_half = (bus.i_sizemem == 2'b01);

    assign w_align_err  = (w_is_half & w_off[0]) |
                          (~w_is_byte & ~w_is_half & (w_off != 2'b00));
    assign w_misaligned = (w_mem_read | w_mem_write) & w_align_err;
    // A store presented during reset must not commit.
    assign w_do_store   = w_mem_write & ~w_align_err & ~i_reset;
    // Read+write together is a store only, so no load data.
    assign w_do_load    = w_mem_read & ~w_mem_write & ~w_align_err;

    // Store data is replicated across lanes; byte enables pick the lane(s).
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.i_regB;
        if (w_is_byte) begin
            w_wdata = {4{bus.i_regB[7:0]}};
            case (w_off)
                2'b00:   w_be = 4'b0001;
                2'b01:   w_be = 4'b0010;
                2'b10:   w_be = 4'b0100;
                default: w_be = 4'b1000;
            endcase
        end else if (w_is_half) begin
            w_wdata = {2{bus.i_regB[15:0]}};
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign w_word = r_mem[w_idx];

    always_comb begin
        case (w_off)
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_loadval = w_word;
        if (w_is_byte) begin
            w_loadval = {{24{bus.i_signedmem & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_loadval = {{16{bus.i_signedmem & w_half[15]}}, w_half};
        end
    end

    assign w_readdata = w_do_load ? w_loadval : 32'h0;

    always_ff @(posedge i_clock) begin
        if (w_do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_readdata   <= 32'h0;
            r_aluresult  <= 32'h0;
            r_rd_rt      <= 5'h0;
            r_wb         <= 2'b00;
            r_misaligned <= 1'b0;
        end else begin
            r_readdata   <= w_readdata;
            r_aluresult  <= bus.i_aluresult;
            r_rd_rt      <= bus.i_rd_rt;
            // Misaligned loads must not write back; stores keep their wb bits.
            r_wb         <= {bus.i_wb[1],
                             bus.i_wb[0] & ~(w_misaligned & w_mem_read)};
            r_misaligned <= w_misaligned;
        end
    end

    assign bus.o_readdata   = r_readdata;
    assign bus.o_aluresult  = r_aluresult;
    assign bus.o_rd_rt      = r_rd_rt;
    assign bus.o_wb         = r_wb;
    assign bus.o_misaligned = r_misaligned;
    assign bus.o_debug_data = r_mem[bus.i_debug_addr];

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed bench for mem_stage: hand-written reset sequences followed by a
// table of {inputs, expected outputs} vectors applied one per clock.
module tb_mem_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_stage_if #(.ADDR_WIDTH(8)) bus ();

    mem_stage #(
        .DATA_WIDTH(32),
        .MEM_DEPTH (256),
        .ADDR_WIDTH(8)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] regb;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic [1:0]  exp_wb;
        logic        dchk;
        logic [7:0]  daddr;
        logic [31:0] dexp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] mem, logic [1:0] wb, logic [1:0] size,
                                logic sgn, logic [31:0] addr, logic [31:0] regb,
                                logic [4:0] rd, logic [31:0] exp_rdata,
                                logic exp_mis, logic [1:0] exp_wb, logic dchk,
                                logic [7:0] daddr, logic [31:0] dexp);
        vec_t v;
        v.mem = mem; v.wb = wb; v.size = size; v.sgn = sgn; v.addr = addr;
        v.regb = regb; v.rd = rd; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
        v.exp_wb = exp_wb; v.dchk = dchk; v.daddr = daddr; v.dexp = dexp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] mem, input logic [1:0] wb,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] regb,
                         input logic [4:0] rd, input logic [7:0] daddr);
        @(negedge clk);
        bus.i_mem        = mem;
        bus.i_wb         = wb;
        bus.i_sizemem    = size;
        bus.i_signedmem  = sgn;
        bus.i_aluresult  = addr;
        bus.i_regB       = regb;
        bus.i_rd_rt      = rd;
        bus.i_debug_addr = daddr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;

        // Initial reset with a bubble.
        drive(3'b000, 2'b00, 2'b11, 1'b0, 32'h0, 32'h0, 5'd0, 8'd4);
        drive(3'b000, 2'b00, 2'b11, 1'b0, 32'h0, 32'h0, 5'd0, 8'd4);
        rst = 1'b0;

        // Known content at word 4, then a load of it in flight.
        drive(3'b010, 2'b00, 2'b11, 1'b0, 32'h10, 32'h11112222, 5'd0, 8'd4);
        check("preload_dbg_w4", bus.o_debug_data, 32'h11112222);
        drive(3'b001, 2'b11, 2'b11, 1'b0, 32'h10, 32'h0, 5'd9, 8'd4);
        check("inflight_rdata", bus.o_readdata, 32'h11112222);

        // Reset with a store presented: outputs clear, store suppressed.
        rst = 1'b1;
        drive(3'b010, 2'b11, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 5'd5, 8'd4);
        check("rst_rdata", bus.o_readdata, 32'h0);
        check("rst_alu", bus.o_aluresult, 32'h0);
        check("rst_rd", {27'h0, bus.o_rd_rt}, 32'h0);
        check("rst_wb", {30'h0, bus.o_wb}, 32'h0);
        check("rst_mis", {31'h0, bus.o_misaligned}, 32'h0);
        check("rst_dbg_w4", bus.o_debug_data, 32'h11112222);
        rst = 1'b0;

        // First instruction after reset is processed normally.
        drive(3'b001, 2'b11, 2'b11, 1'b0, 32'h10, 32'h0, 5'd9, 8'd4);
        check("post_rst_rdata", bus.o_readdata, 32'h11112222);
        check("post_rst_wb", {30'h0, bus.o_wb}, 32'h3);
        check("post_rst_rd", {27'h0, bus.o_rd_rt}, 32'd9);

        //            mem     wb     size   sg  addr          regb          rd     exp_rdata     mis   exp_wb dchk  da     dexp
        vecs.push_back(mk(3'b010, 2'b00, 2'b11, 0, 32'h20,  32'h803412F0, 5'd3,  32'h0,        0, 2'b00, 1, 8'd8,  32'h803412F0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b11, 0, 32'h20,  32'h0,        5'd7,  32'h803412F0, 0, 2'b11, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b00, 1, 32'h20,  32'h0,        5'd8,  32'hFFFFFFF0, 0, 2'b11, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b00, 0, 32'h20,  32'h0,        5'd9,  32'h000000F0, 0, 2'b11, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b01, 1, 32'h22,  32'h0,        5'd10, 32'hFFFF8034, 0, 2'b11, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b01, 0, 32'h22,  32'h0,        5'd11, 32'h00008034, 0, 2'b11, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b010, 2'b00, 2'b00, 0, 32'h21,  32'h000000AB, 5'd0,  32'h0,        0, 2'b00, 1, 8'd8,  32'h8034ABF0));
        vecs.push_back(mk(3'b010, 2'b00, 2'b01, 0, 32'h22,  32'hFFFF1234, 5'd0,  32'h0,        0, 2'b00, 1, 8'd8,  32'h1234ABF0));
        vecs.push_back(mk(3'b001, 2'b01, 2'b11, 0, 32'h22,  32'h0,        5'd12, 32'h0,        1, 2'b00, 0, 8'd8,  32'h0));
        vecs.push_back(mk(3'b010, 2'b01, 2'b01, 0, 32'h21,  32'h00005555, 5'd13, 32'h0,        1, 2'b01, 1, 8'd8,  32'h1234ABF0));
        vecs.push_back(mk(3'b010, 2'b00, 2'b11, 0, 32'h400, 32'h00000055, 5'd0,  32'h0,        0, 2'b00, 1, 8'd0,  32'h00000055));
        vecs.push_back(mk(3'b001, 2'b11, 2'b11, 0, 32'h0,   32'h0,        5'd14, 32'h00000055, 0, 2'b11, 0, 8'd0,  32'h0));
        vecs.push_back(mk(3'b000, 2'b00, 2'b11, 0, 32'h12345678, 32'h0,   5'd0,  32'h0,        0, 2'b00, 0, 8'd0,  32'h0));
        vecs.push_back(mk(3'b011, 2'b10, 2'b11, 0, 32'h30,  32'hCAFEF00D, 5'd15, 32'h0,        0, 2'b10, 1, 8'd12, 32'hCAFEF00D));
        vecs.push_back(mk(3'b001, 2'b11, 2'b10, 0, 32'h30,  32'h0,        5'd16, 32'hCAFEF00D, 0, 2'b11, 0, 8'd12, 32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b00, 1, 32'h33,  32'h0,        5'd17, 32'hFFFFFFCA, 0, 2'b11, 0, 8'd12, 32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b00, 1, 32'h31,  32'h0,        5'd18, 32'hFFFFFFF0, 0, 2'b11, 0, 8'd12, 32'h0));
        vecs.push_back(mk(3'b001, 2'b11, 2'b01, 1, 32'h31,  32'h0,        5'd19, 32'h0,        1, 2'b10, 0, 8'd12, 32'h0));
        vecs.push_back(mk(3'b010, 2'b01, 2'b10, 0, 32'h32,  32'h99999999, 5'd20, 32'h0,        1, 2'b01, 1, 8'd12, 32'hCAFEF00D));

        foreach (vecs[i]) begin
            drive(vecs[i].mem, vecs[i].wb, vecs[i].size, vecs[i].sgn,
                  vecs[i].addr, vecs[i].regb, vecs[i].rd, vecs[i].daddr);
            check($sformatf("v%0d_rdata", i), bus.o_readdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_alu", i), bus.o_aluresult, vecs[i].addr);
            check($sformatf("v%0d_rd", i), {27'h0, bus.o_rd_rt}, {27'h0, vecs[i].rd});
            check($sformatf("v%0d_wb", i), {30'h0, bus.o_wb}, {30'h0, vecs[i].exp_wb});
            check($sformatf("v%0d_mis", i), {31'h0, bus.o_misaligned},
                  {31'h0, vecs[i].exp_mis});
            if (vecs[i].dchk) begin
                check($sformatf("v%0d_dbg", i), bus.o_debug_data, vecs[i].dexp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM pipeline register. It performs byte/halfword/word loads and stores against an internal data memory with signed/unsigned load extension. It also registers its results as the MEM/WB pipeline register consumed by write-back, and exposes a combinational word-read debug port for the debug unit.

## Interface
- DATA_WIDTH, 32, datapath width (fixed at 32 for lane logic)
- MEM_DEPTH, 256, number of 32-bit words in data memory
- ADDR_WIDTH, 8, log2(MEM_DEPTH); word index width
- i_clock  input  1  single clock for the block; all state changes on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_aluresult  input  32  byte address for loads/stores; pass-through value otherwise
- i_regB  input  32  store data
- i_rd_rt  input  5  destination register, passed through
- i_mem  input  3  [0] mem_read, [1] mem_write, [2] branch (ignored here)
- i_wb  input  2  [0] reg_write, [1] mem_to_reg; passed through
- i_sizemem  input  2  00 byte, 01 halfword, 11 word, 10 treated as word
- i_signedmem  input  1  1 = sign-extend loads, 0 = zero-extend
- i_debug_addr  input  ADDR_WIDTH  word index for debug read
- o_readdata  output  32  extended load data (MEM/WB)
- o_aluresult  output  32  registered i_aluresult (MEM/WB)
- o_rd_rt  output  5  registered i_rd_rt
- o_wb  output  2  registered i_wb, with [0] forced 0 on misaligned load
- o_misaligned  output  1  registered flag: misaligned access this instruction
- o_debug_data  output  32  memory word at i_debug_addr, combinational

## Operation
- Addressing: byte address A = i_aluresult; word index = A[ADDR_WIDTH+1:2]; upper bits ignored (wraps modulo MEM_DEPTH words). Little-endian: byte lane k = bits [8k+7:8k].
- Alignment: halfword requires A[0]=0; word requires A[1:0]=00; byte always aligned. Misaligned = (mem_read|mem_write) & alignment violated.
- Store (mem_write=1, aligned): byte writes lane A[1:0] with i_regB[7:0]; halfword writes lanes {A[1],1},{A[1],0} with i_regB[15:0]; word writes all 32 bits. Other lanes untouched.
- Load (mem_read=1, mem_write=0, aligned): selects the byte or halfword at A, extending to 32 bits (sign bit = MSB of selected field if i_signedmem, else zeros). A word load is returned unchanged.
- mem_read and mem_write both 1: treated as store only; o_readdata = 0.
- Misaligned access: no memory write; o_readdata = 0; o_misaligned = 1; o_wb[0] = 0 only if mem_read=1 (store passes o_wb unchanged).
- No memory access (mem_read=mem_write=0): o_readdata = 0; memory unchanged.
- Memory contents are not cleared by reset; the bench preloads memory via a hierarchical reference or prior stores.

## Timing
- Latency 1: inputs sampled at rising edge N; all registered outputs valid after edge N, until edge N+1.
- Store commits at edge N. A load at the same address sampled at edge N+1 returns the new data. There is no forwarding within the same edge.
- o_debug_data reflects memory combinationally: it shows a store's data right after the committing edge.
- Reset (i_reset high at an edge): o_readdata=0, o_aluresult=0, o_rd_rt=0, o_wb=00, o_misaligned=0. Any store presented in that cycle is suppressed. Reset mid-stream drops the in-flight instruction. The first instruction after reset deasserts is processed normally.
- No stall/flush inputs; every cycle is one instruction (bubbles arrive as i_mem=000, i_wb=00).

## Test plan
- Reset: drive i_reset=1 with i_mem=010, A=0x10, i_regB=0xDEADBEEF. Required: all outputs 0, and o_debug_data at word 4 is unchanged.
- Word store/load: store 0x8034_12F0 at A=0x20, then word load at A=0x20 next cycle. Required: o_readdata=0x803412F0; o_wb/o_rd_rt match inputs.
- Byte lanes + extension: after that word store, signed byte load at A=0x20 gives 0xFFFFFFF0, and unsigned gives 0x000000F0. Signed halfword at A=0x22 gives 0xFFFF8034; unsigned halfword at A=0x22 gives 0x00008034.
- Partial store: byte store of i_regB=0x000000AB at A=0x21 over 0x803412F0. Required: o_debug_data(word 8)=0x8034ABF0. Then a halfword store of 0x1234 at A=0x22 gives 0x1234ABF0.
- Misaligned: word load at A=0x22 with i_wb=01. Required: o_misaligned=1, o_readdata=0, o_wb=00. Halfword store at A=0x21 leaves memory unchanged with o_misaligned=1.
- Wrap/back-to-back: store 0x55 (word) at A=0x400 (word index 0 with MEM_DEPTH=256), then load from A=0x0 in consecutive cycles. Required: o_readdata=0x00000055.
